// File: rtl/iq_4interp_if.sv
// I/Q 4x interpolator stream interface.
// The sample source/sink side is master; the interpolator is slave.
interface iq_4interp_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         strobe_in;
  logic signed [DATA_WIDTH-1:0] I_in;
  logic signed [DATA_WIDTH-1:0] Q_in;
  logic                         in_ready;
  logic                         tick;
  logic signed [DATA_WIDTH-1:0] I_out;
  logic signed [DATA_WIDTH-1:0] Q_out;
  logic                         strobe_out;
  logic                         underrun;
  logic                         underrun_sticky;

  modport master (
    output strobe_in, I_in, Q_in, tick,
    input  in_ready, I_out, Q_out,
    input  strobe_out, underrun, underrun_sticky
  );

  modport slave (
    input  strobe_in, I_in, Q_in, tick,
    output in_ready, I_out, Q_out,
    output strobe_out, underrun, underrun_sticky
  );
endinterface

// File: rtl/iq_4interp.sv
// I/Q 4x linear-interpolating upsampler.
// One input pair becomes four tick-paced output pairs.
module iq_4interp #(
  parameter int DATA_WIDTH = 16
) (
  input logic       clk,
  input logic       aresetn,
  input logic       ce,
  iq_4interp_if.slave io
);
  localparam int W1 = DATA_WIDTH + 1;
  localparam int W3 = DATA_WIDTH + 3;

  typedef logic signed [DATA_WIDTH-1:0] smp_t;
  typedef logic signed [W3-1:0] acc_t;
  typedef enum logic {IDLE, RUN} state_t;

  function automatic acc_t prod_f(smp_t c, smp_t p,
                                  logic [1:0] k);
    logic signed [W1-1:0] d;
    d = W1'(c) - W1'(p);
    return W3'(d) * W3'($signed({1'b0, k}));
  endfunction

  function automatic acc_t base_f(smp_t p);
    return W3'(p) <<< 2;
  endfunction

  function automatic smp_t out_f(acc_t b, acc_t pr);
    acc_t s;
    s = b + pr;
    return DATA_WIDTH'(s >>> 2);
  endfunction

  state_t     state, state_nx;
  logic       start;
  smp_t       prev_i, prev_q, cur_i, cur_q;
  smp_t       nxt_i, nxt_q, out_i, out_q;
  logic       nxt_valid;
  logic [1:0] phase;
  acc_t       base_i, base_q, prod_i, prod_q;
  logic       s1_valid, str_q, und_q, sticky;
  logic       accept, fire, bound;

  assign accept = ce & io.strobe_in & ~nxt_valid;
  assign fire   = ce & (state == RUN) & io.tick;
  assign bound  = fire & (phase == 2'd3);

  assign io.in_ready        = ~nxt_valid;
  assign io.I_out           = out_i;
  assign io.Q_out           = out_q;
  assign io.strobe_out      = str_q & ce;
  assign io.underrun        = und_q & ce;
  assign io.underrun_sticky = sticky;

  // Leave IDLE as soon as a first sample is waiting.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    if (ce && state == IDLE && nxt_valid) begin
      state_nx = RUN;
      start    = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Holding register, segment endpoints and phase.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      nxt_i     <= '0;
      nxt_q     <= '0;
      nxt_valid <= 1'b0;
      prev_i    <= '0;
      prev_q    <= '0;
      cur_i     <= '0;
      cur_q     <= '0;
      phase     <= '0;
    end else if (ce) begin
      if (accept) begin
        nxt_i <= io.I_in;
        nxt_q <= io.Q_in;
      end
      if (accept)
        nxt_valid <= 1'b1;
      else if (start || (bound && nxt_valid))
        nxt_valid <= 1'b0;
      if (start) begin
        prev_i <= '0;
        prev_q <= '0;
        cur_i  <= nxt_i;
        cur_q  <= nxt_q;
        phase  <= '0;
      end else if (fire) begin
        phase <= phase + 2'd1;
        if (bound) begin
          prev_i <= cur_i;
          prev_q <= cur_q;
          if (nxt_valid) begin
            cur_i <= nxt_i;
            cur_q <= nxt_q;
          end
        end
      end
    end
  end

  // Two-stage interpolation pipeline and status pulses.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      base_i   <= '0;
      base_q   <= '0;
      prod_i   <= '0;
      prod_q   <= '0;
      str_q    <= 1'b0;
      out_i    <= '0;
      out_q    <= '0;
      und_q    <= 1'b0;
      sticky   <= 1'b0;
    end else if (ce) begin
      s1_valid <= fire;
      if (fire) begin
        base_i <= base_f(prev_i);
        base_q <= base_f(prev_q);
        prod_i <= prod_f(cur_i, prev_i, phase);
        prod_q <= prod_f(cur_q, prev_q, phase);
      end
      str_q <= s1_valid;
      if (s1_valid) begin
        out_i <= out_f(base_i, prod_i);
        out_q <= out_f(base_q, prod_q);
      end
      und_q <= bound & ~nxt_valid;
      if (bound && !nxt_valid) sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_iq_4interp.sv
// Testbench for iq_4interp.
// Outputs compared against a segment-level interpolation model.
module tb_iq_4interp;
  localparam int DW = 16;
  typedef logic signed [DW-1:0] smp_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic ce = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  smp_t qi[$];
  smp_t qq[$];
  int   qcyc[$];
  int   ucyc[$];
  int   tcyc[$];

  iq_4interp_if #(.DATA_WIDTH(DW)) io();

  iq_4interp #(.DATA_WIDTH(DW)) dut (
    .clk(clk),
    .aresetn(aresetn),
    .ce(ce),
    .io(io.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture what downstream consumes, just before each edge.
  always @(negedge clk) begin
    #4;
    if (io.strobe_out === 1'b1) begin
      qi.push_back(io.I_out);
      qq.push_back(io.Q_out);
      qcyc.push_back(cyc);
    end
    if (io.underrun === 1'b1) ucyc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // floor((p*(4-k) + c*k) / 4)
  function automatic int interp(int p, int c, int k);
    int x;
    x = p * (4 - k) + c * k;
    if (x >= 0) return x / 4;
    return -((-x + 3) / 4);
  endfunction

  task automatic clear_q();
    qi.delete();
    qq.delete();
    qcyc.delete();
    ucyc.delete();
    tcyc.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    ce = 1'b1;
    io.strobe_in = 1'b0;
    io.tick = 1'b0;
    io.I_in = '0;
    io.Q_in = '0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    clear_q();
    @(negedge clk);
  endtask

  task automatic send(input smp_t i, input smp_t q);
    int w;
    w = 0;
    while (io.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_total++;
      $display("FAIL send_timeout in_ready=%b want 1",
               io.in_ready);
    end
    io.I_in = i;
    io.Q_in = q;
    io.strobe_in = 1'b1;
    @(negedge clk);
    io.strobe_in = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    for (int t = 0; t < n; t++) begin
      io.tick = 1'b1;
      tcyc.push_back(cyc);
      @(negedge clk);
      io.tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    ce = 1'b1;
    io.strobe_in = 1'b0;
    io.tick = 1'b0;
    io.I_in = '0;
    io.Q_in = '0;
    @(negedge clk);
    n_total++;
    if (io.I_out !== '0 || io.Q_out !== '0)
      $display("FAIL reset_out got %0d,%0d want 0,0",
               io.I_out, io.Q_out);
    else n_pass++;
    n_total++;
    if (io.in_ready !== 1'b1)
      $display("FAIL reset_ready got %b want 1", io.in_ready);
    else n_pass++;
    n_total++;
    if (io.strobe_out !== 1'b0 || io.underrun !== 1'b0)
      $display("FAIL reset_pulses got %b%b want 00",
               io.strobe_out, io.underrun);
    else n_pass++;
    n_total++;
    if (io.underrun_sticky !== 1'b0)
      $display("FAIL reset_sticky got %b want 0",
               io.underrun_sticky);
    else n_pass++;
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    io.I_in = 16'sd100;
    io.Q_in = -16'sd100;
    io.strobe_in = 1'b1;
    @(negedge clk);
    io.strobe_in = 1'b0;
    n_total++;
    if (io.in_ready !== 1'b0)
      $display("FAIL basic_ready_full got %b want 0",
               io.in_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (io.in_ready !== 1'b1)
      $display("FAIL basic_ready_xfer got %b want 1",
               io.in_ready);
    else n_pass++;
    ticks(4, 4);
    repeat (3) @(negedge clk);
    n_total++;
    if (qi.size() < 4)
      $display("FAIL basic_count got %0d want 4", qi.size());
    else n_pass++;
    for (int n = 0; n < 4; n++) begin
      int ei, eq;
      ei = interp(0, 100, n);
      eq = interp(0, -100, n);
      n_total++;
      if (n >= qi.size() || int'(qi[n]) !== ei
          || int'(qq[n]) !== eq)
        $display("FAIL basic_out%0d got %0d,%0d want %0d,%0d",
                 n, qi[n], qq[n], ei, eq);
      else n_pass++;
      n_total++;
      if (n >= qcyc.size() || qcyc[n] !== tcyc[n] + 2)
        $display("FAIL basic_lat%0d got %0d want %0d",
                 n, qcyc[n], tcyc[n] + 2);
      else n_pass++;
    end
  endtask

  task automatic test_neg_round();
    smp_t i2;
    int si[2], sq[2];
    do_reset();
    i2 = 16'($urandom);
    si[0] = -3;
    sq[0] = -32768;
    si[1] = i2;
    sq[1] = 32767;
    send(16'(si[0]), 16'(sq[0]));
    @(negedge clk);
    send(i2, 16'sd32767);
    ticks(8, 1);
    repeat (3) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      int j, k, ei, eq;
      j = n / 4;
      k = n % 4;
      ei = interp(j == 0 ? 0 : si[0], si[j], k);
      eq = interp(j == 0 ? 0 : sq[0], sq[j], k);
      n_total++;
      if (n >= qi.size() || int'(qi[n]) !== ei
          || int'(qq[n]) !== eq)
        $display("FAIL round_out%0d got %0d,%0d want %0d,%0d",
                 n, qi[n], qq[n], ei, eq);
      else n_pass++;
    end
  endtask

  task automatic test_underrun();
    do_reset();
    send(16'sd40, -16'sd20);
    @(negedge clk);
    ticks(8, 4);
    repeat (3) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      int p, c, ei, eq;
      p = n < 4 ? 0 : 40;
      c = 40;
      ei = interp(p, c, n % 4);
      eq = interp(n < 4 ? 0 : -20, -20, n % 4);
      n_total++;
      if (n >= qi.size() || int'(qi[n]) !== ei
          || int'(qq[n]) !== eq)
        $display("FAIL under_out%0d got %0d,%0d want %0d,%0d",
                 n, qi[n], qq[n], ei, eq);
      else n_pass++;
    end
    n_total++;
    if (ucyc.size() != 2 || ucyc[0] !== tcyc[3] + 1
        || ucyc[1] !== tcyc[7] + 1)
      $display("FAIL under_pulse got n=%0d at %0d want %0d",
               ucyc.size(), ucyc[0], tcyc[3] + 1);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if (io.underrun_sticky !== 1'b1)
      $display("FAIL under_sticky got %b want 1",
               io.underrun_sticky);
    else n_pass++;
    do_reset();
    n_total++;
    if (io.underrun_sticky !== 1'b0)
      $display("FAIL under_sticky_clr got %b want 0",
               io.underrun_sticky);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    smp_t di, dq;
    int ai[$], aq[$];
    bit rdy_last, full_ok, cont;
    do_reset();
    full_ok = 1'b1;
    cont = 1'b1;
    di = 16'($urandom);
    dq = 16'($urandom);
    io.I_in = di;
    io.Q_in = dq;
    io.strobe_in = 1'b1;
    io.tick = 1'b1;
    rdy_last = io.in_ready;
    for (int c = 0; c < 300 && qi.size() < 40; c++) begin
      @(negedge clk);
      if (rdy_last) begin
        ai.push_back(int'(di));
        aq.push_back(int'(dq));
        if (io.in_ready !== 1'b0) full_ok = 1'b0;
      end
      rdy_last = io.in_ready;
      di = 16'($urandom);
      dq = 16'($urandom);
      io.I_in = di;
      io.Q_in = dq;
    end
    io.strobe_in = 1'b0;
    io.tick = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (qi.size() < 40 || ai.size() < 10)
      $display("FAIL b2b_count got %0d/%0d want 40/10",
               qi.size(), ai.size());
    else n_pass++;
    for (int n = 1; n < 40 && n < qcyc.size(); n++)
      if (qcyc[n] != qcyc[n-1] + 1) cont = 1'b0;
    n_total++;
    if (!cont)
      $display("FAIL b2b_rate got gaps want 1 per cycle");
    else n_pass++;
    n_total++;
    if (!full_ok)
      $display("FAIL b2b_ready got 1 want 0 when full");
    else n_pass++;
    n_total++;
    if (ucyc.size() != 0)
      $display("FAIL b2b_underrun got %0d want 0",
               ucyc.size());
    else n_pass++;
    for (int n = 0; n < 40; n++) begin
      int j, k, ei, eq;
      j = n / 4;
      k = n % 4;
      if (j < ai.size()) begin
        ei = interp(j == 0 ? 0 : ai[j-1], ai[j], k);
        eq = interp(j == 0 ? 0 : aq[j-1], aq[j], k);
        n_total++;
        if (n >= qi.size() || int'(qi[n]) !== ei
            || int'(qq[n]) !== eq)
          $display("FAIL b2b_out%0d got %0d,%0d want %0d,%0d",
                   n, qi[n], qq[n], ei, eq);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ce_gating();
    smp_t s1i, s1q, s2i, s2q;
    int   qsz;
    int   si[2], sq[2];
    do_reset();
    s1i = 16'($urandom);
    s1q = 16'($urandom);
    s2i = 16'($urandom);
    s2q = 16'($urandom);
    si[0] = s1i;
    sq[0] = s1q;
    si[1] = s2i;
    sq[1] = s2q;
    send(s1i, s1q);
    @(negedge clk);
    ticks(2, 1);
    qsz = qi.size();
    ce = 1'b0;
    io.tick = 1'b1;
    io.strobe_in = 1'b1;
    io.I_in = 16'($urandom);
    io.Q_in = 16'($urandom);
    repeat (5) @(negedge clk);
    n_total++;
    if (qi.size() != qsz)
      $display("FAIL ce_gap_out got %0d want %0d",
               qi.size(), qsz);
    else n_pass++;
    n_total++;
    if (io.in_ready !== 1'b1)
      $display("FAIL ce_gap_accept got %b want 1",
               io.in_ready);
    else n_pass++;
    ce = 1'b1;
    io.tick = 1'b0;
    io.strobe_in = 1'b0;
    send(s2i, s2q);
    ticks(6, 1);
    repeat (3) @(negedge clk);
    n_total++;
    if (qi.size() != 8)
      $display("FAIL ce_count got %0d want 8", qi.size());
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      int j, k, ei, eq;
      j = n / 4;
      k = n % 4;
      ei = interp(j == 0 ? 0 : si[0], si[j], k);
      eq = interp(j == 0 ? 0 : sq[0], sq[j], k);
      n_total++;
      if (n >= qi.size() || int'(qi[n]) !== ei
          || int'(qq[n]) !== eq)
        $display("FAIL ce_out%0d got %0d,%0d want %0d,%0d",
                 n, qi[n], qq[n], ei, eq);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    smp_t s1i, s3i, s3q;
    do_reset();
    s1i = 16'($urandom);
    s3i = 16'($urandom);
    s3q = 16'($urandom);
    send(s1i, -s1i);
    @(negedge clk);
    ticks(2, 1);
    repeat (2) @(negedge clk);
    n_total++;
    if (qi.size() != 2)
      $display("FAIL mid_pre got %0d want 2", qi.size());
    else n_pass++;
    io.tick = 1'b1;
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    n_total++;
    if (io.I_out !== '0 || io.Q_out !== '0
        || io.strobe_out !== 1'b0)
      $display("FAIL mid_rst_out got %0d,%0d,%b want 0,0,0",
               io.I_out, io.Q_out, io.strobe_out);
    else n_pass++;
    n_total++;
    if (io.in_ready !== 1'b1)
      $display("FAIL mid_rst_ready got %b want 1",
               io.in_ready);
    else n_pass++;
    @(negedge clk);
    aresetn = 1'b1;
    clear_q();
    repeat (8) @(negedge clk);
    io.tick = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (qi.size() != 0)
      $display("FAIL mid_idle got %0d want 0", qi.size());
    else n_pass++;
    send(s3i, s3q);
    @(negedge clk);
    ticks(4, 1);
    repeat (3) @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      int ei, eq;
      ei = interp(0, int'(s3i), n);
      eq = interp(0, int'(s3q), n);
      n_total++;
      if (n >= qi.size() || int'(qi[n]) !== ei
          || int'(qq[n]) !== eq)
        $display("FAIL mid_out%0d got %0d,%0d want %0d,%0d",
                 n, qi[n], qq[n], ei, eq);
      else n_pass++;
    end
  endtask

  initial begin
    io.strobe_in = 1'b0;
    io.tick = 1'b0;
    io.I_in = '0;
    io.Q_in = '0;
    test_reset();
    test_basic();
    test_neg_round();
    test_underrun();
    test_back_to_back();
    test_ce_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/iq_4interp.md
Name: iq_4interp

Overview:
- Transmit-side counterpart of the 4-sample I/Q sum decimator: upsamples an I/Q stream by 4 using linear interpolation.
- Accepts one I/Q pair per input strobe and emits four interpolated pairs, each paced by a downstream output-rate tick.
- Sits between the baseband sample source and the DAC-rate datapath.
- Has a one-deep input holding register with a ready handshake, and flags underrun when the source falls behind.

Parameters:
- DATA_WIDTH, 16, signed width of the I/Q input and output samples.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- ce  in  1  clock enable; low freezes all state, and strobe_out and underrun are forced low
- strobe_in  in  1  input sample valid; transfer when strobe_in & ce & in_ready
- I_in  in  DATA_WIDTH  signed in-phase input
- Q_in  in  DATA_WIDTH  signed quadrature input
- in_ready  out  1  high when the holding register is empty (= !nxt_valid, a registered flag)
- tick  in  1  output-rate strobe, nominally 4x the input rate; may be high every cycle
- I_out  out  DATA_WIDTH  signed interpolated in-phase output
- Q_out  out  DATA_WIDTH  signed interpolated quadrature output
- strobe_out  out  1  one-cycle pulse, I_out/Q_out valid
- underrun  out  1  one-cycle pulse, no sample available at a segment boundary
- underrun_sticky  out  1  latched underrun, cleared only by reset

Behaviour:
- Async reset (aresetn=0):
  - prev, cur, nxt, I_out, Q_out = 0.
  - phase = 0; nxt_valid = 0; running = 0.
  - strobe_out, underrun, underrun_sticky = 0; in_ready = 1.
  - Reset mid-operation discards all samples immediately, with no partial output afterwards.
- Input handshake:
  - An accepted sample loads nxt and sets nxt_valid.
  - nxt_valid clears only when nxt is transferred to cur.
  - in_ready is driven from registered state only.
  - A sample accepted in the same cycle as a boundary is not visible to that boundary.
- Start-up (running=0):
  - Ticks are ignored; no strobe_out.
  - When nxt_valid=1: prev<=0, cur<=nxt, nxt_valid<=0, phase<=0, running<=1. This is independent of tick, and the first segment ramps from 0.
- Running, on each tick with ce=1:
  - Output index k=phase; phase<=phase+1 mod 4.
  - When k==3 (segment boundary):
    - If nxt_valid: prev<=cur, cur<=nxt, nxt_valid<=0.
    - Else: prev<=cur, cur unchanged, underrun pulses one cycle later, underrun_sticky<=1. The following segment outputs a constant cur.
- Arithmetic, per channel, fully pipelined:
  - Stage 1 (on tick): diff=cur-prev (DATA_WIDTH+1 signed); prod=diff*k (DATA_WIDTH+3 signed); base=prev<<<2.
  - Stage 2: sum=base+prod (DATA_WIDTH+3); out=sum>>>2 (arithmetic shift, floor), truncated to DATA_WIDTH. The result always lies between prev and cur, so it cannot overflow.
  - Stages use the prev/cur values before any same-cycle boundary update.
- Latency: tick in cycle t gives strobe_out and valid I_out/Q_out in cycle t+2. Outputs hold between strobes.
- Throughput: back-to-back ticks are supported, one output per tick.
- ce=0: tick and strobe_in ignored; pipeline stages hold; strobe_out=0.

Test Plan:
- Reset, then present I_in=100, Q_in=-100, then tick every 4 cycles:
  - Outputs (I,Q): (0,0), (25,-25), (50,-50), (75,-75).
  - Each strobe_out arrives 2 cycles after its tick.
  - in_ready returns high the cycle after the transfer.
- Negative rounding: from I=0 toward I=-3, with ample input supply:
  - I_out sequence 0, -1, -2, -3 (floor).
  - Extremes: -32768 to 32767 gives no wrap; mid value = -1.
- Underrun:
  - Feed a single sample 40; no further input; continue ticks.
  - Outputs 0, 10, 20, 30, then underrun pulse, then 40, 40, 40, 40.
  - underrun_sticky=1 until reset.
- Back-to-back:
  - tick held high continuously; source refills immediately on each in_ready.
  - One strobe_out every cycle; no underrun; in_ready low whenever nxt is full.
  - A second strobe_in while in_ready=0 is not accepted.
- ce gating:
  - Drop ce for 5 cycles mid-segment with tick and strobe_in high.
  - No outputs and no acceptance during the gap; the sequence resumes at the same k with identical values.
- Reset mid-segment after 2 outputs:
  - All outputs 0, in_ready=1, running=0.
  - A new sample restarts the ramp from 0.
